// File: rtl/adc3wire_rx_if.sv
// rtl/adc3wire_rx_if.sv - register-bank read port and write/error report bundle for adc3wire_rx
// err_count exists only when ADC3WIRE_RX_ERRCNT_EN is defined.
interface adc3wire_rx_if;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic        wr_valid;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        frame_err;
`ifdef ADC3WIRE_RX_ERRCNT_EN
    logic [7:0]  err_count;

    modport master (
        input  rd_addr,
        output rd_data, wr_valid, wr_addr, wr_data, frame_err, err_count
    );
    modport slave (
        output rd_addr,
        input  rd_data, wr_valid, wr_addr, wr_data, frame_err, err_count
    );
`else
    modport master (
        input  rd_addr,
        output rd_data, wr_valid, wr_addr, wr_data, frame_err
    );
    modport slave (
        output rd_addr,
        input  rd_data, wr_valid, wr_addr, wr_data, frame_err
    );
`endif
endinterface

// File: rtl/adc3wire_rx.sv
// rtl/adc3wire_rx.sv - three-wire serial frame receiver writing a 16x16 register bank
// Define ADC3WIRE_RX_ERRCNT_EN to add the saturating rejected-frame counter err_count.
module adc3wire_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [11:0] HEADER      = 12'h001
) (
    input  logic          OPB_Clk,
    input  logic          OPB_Rst,
    input  logic          adc3wire_clk,
    input  logic          adc3wire_data,
    input  logic          adc3wire_strobe,
    adc3wire_rx_if.master regs
);
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam int unsigned SETTLE = SYNC_STAGES + 1;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] sdat_sync_q, sdat_sync_d;
    logic [SYNC_STAGES-1:0] strb_sync_q, strb_sync_d;
    logic                   sclk_dly_q, sclk_dly_d;
    logic                   strb_dly_q, strb_dly_d;
    logic [SETTLE-1:0]      settle_q, settle_d;

    state_t      state_q, state_d;
    logic [31:0] shift_q, shift_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        wr_valid_q, wr_valid_d;
    logic        frame_err_q, frame_err_d;
    logic [3:0]  wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic [15:0] bank_q [16];

    logic sclk_s, sdat_s, strb_s, settled;
    logic clk_rise, strb_fall, strb_rise;

    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign sdat_s  = sdat_sync_q[SYNC_STAGES-1];
    assign strb_s  = strb_sync_q[SYNC_STAGES-1];
    // Edges are only trusted once the reset values have flushed out of the
    // synchronizer and delay flops, so a strobe already low at reset release
    // never looks like a fresh frame start.
    assign settled = settle_q[SETTLE-1];

    assign clk_rise  = settled &  sclk_s & ~sclk_dly_q;
    assign strb_fall = settled & ~strb_s &  strb_dly_q;
    assign strb_rise = settled &  strb_s & ~strb_dly_q;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], adc3wire_clk};
        sdat_sync_d = {sdat_sync_q[SYNC_STAGES-2:0], adc3wire_data};
        strb_sync_d = {strb_sync_q[SYNC_STAGES-2:0], adc3wire_strobe};
        sclk_dly_d  = sclk_s;
        strb_dly_d  = strb_s;
        settle_d    = {settle_q[SETTLE-2:0], 1'b1};
        rd_data_d   = bank_q[regs.rd_addr];
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        wr_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        case (state_q)
            IDLE: begin
                if (strb_fall) begin
                    state_d = SHIFT;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (strb_rise) begin
                    state_d = IDLE;
                    if (cnt_q == 6'd32 && shift_q[31:20] == HEADER) begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = shift_q[19:16];
                        wr_data_d  = shift_q[15:0];
                    end else if (cnt_q != 6'd0) begin
                        frame_err_d = 1'b1;
                    end
                end else if (clk_rise) begin
                    shift_d = {shift_q[30:0], sdat_s};
                    cnt_d   = (cnt_q == 6'd33) ? cnt_q : cnt_q + 6'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ADC3WIRE_RX_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (frame_err_d && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign regs.err_count = err_cnt_q;
`endif

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            sclk_sync_q <= '0;
            sdat_sync_q <= '0;
            strb_sync_q <= '1;
            sclk_dly_q  <= 1'b0;
            strb_dly_q  <= 1'b1;
            settle_q    <= '0;
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            wr_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_data_q   <= '0;
            for (int i = 0; i < 16; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            sclk_sync_q <= sclk_sync_d;
            sdat_sync_q <= sdat_sync_d;
            strb_sync_q <= strb_sync_d;
            sclk_dly_q  <= sclk_dly_d;
            strb_dly_q  <= strb_dly_d;
            settle_q    <= settle_d;
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            wr_valid_q  <= wr_valid_d;
            frame_err_q <= frame_err_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            // rd_data_d samples the bank before this edge's write lands.
            rd_data_q   <= rd_data_d;
            if (wr_valid_d) begin
                bank_q[wr_addr_d] <= wr_data_d;
            end
        end
    end

    assign regs.rd_data   = rd_data_q;
    assign regs.wr_valid  = wr_valid_q;
    assign regs.wr_addr   = wr_addr_q;
    assign regs.wr_data   = wr_data_q;
    assign regs.frame_err = frame_err_q;
endmodule

// File: tb/tb_adc3wire_rx.sv
// tb/tb_adc3wire_rx.sv - self-checking bench for adc3wire_rx against a frame-level model
module tb_adc3wire_rx;
    localparam logic [11:0] HDR = 12'h001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk = 1'b0;
    logic sdata = 1'b0;
    logic strobe = 1'b1;

    adc3wire_rx_if bus ();

    adc3wire_rx #(.SYNC_STAGES(2), .HEADER(HDR)) dut (
        .OPB_Clk         (clk),
        .OPB_Rst         (rst),
        .adc3wire_clk    (sclk),
        .adc3wire_data   (sdata),
        .adc3wire_strobe (strobe),
        .regs            (bus.master)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    int wr_seen = 0;
    int err_seen = 0;
    logic [3:0]  last_addr = '0;
    logic [15:0] last_data = '0;
    logic [15:0] rd_at_wr = '0;
    logic [15:0] rd_after_wr = '0;
    logic        grab_next = 1'b0;

    int exp_wr = 0;
    int exp_err = 0;
    int exp_ec = 0;
    logic [3:0]  exp_addr = '0;
    logic [15:0] exp_data = '0;
    logic [15:0] bank_m [16];

    always @(negedge clk) begin
        if (grab_next) begin
            rd_after_wr = bus.rd_data;
            grab_next = 1'b0;
        end
        if (bus.wr_valid) begin
            wr_seen++;
            last_addr = bus.wr_addr;
            last_data = bus.wr_data;
            rd_at_wr = bus.rd_data;
            grab_next = 1'b1;
        end
        if (bus.frame_err) err_seen++;
    end

    // A frame writes only when exactly 32 bits arrived behind the right header.
    task automatic model_frame(input logic [63:0] bits, input int n);
        if (n == 0) return;
        if (n == 32 && bits[31:20] == HDR) begin
            exp_wr++;
            exp_addr = bits[19:16];
            exp_data = bits[15:0];
            bank_m[bits[19:16]] = bits[15:0];
        end else begin
            exp_err++;
            if (exp_ec < 255) exp_ec++;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) bank_m[i] = '0;
        exp_ec = 0;
    endtask

    task automatic send_bits(input logic [63:0] bits, input int hi, input int lo, input int half);
        for (int i = hi; i >= lo; i--) begin
            sdata = bits[i];
            repeat (half) @(negedge clk);
            sclk = 1'b1;
            repeat (half) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [63:0] bits, input int n, input int half, input int gap);
        @(negedge clk);
        strobe = 1'b0;
        repeat (half) @(negedge clk);
        if (n > 0) send_bits(bits, n - 1, 0, half);
        repeat (half) @(negedge clk);
        strobe = 1'b1;
        repeat (gap) @(negedge clk);
        model_frame(bits, n);
    endtask

    task automatic do_read(input logic [3:0] a, output logic [15:0] d);
        @(negedge clk);
        bus.rd_addr = a;
        @(negedge clk);
        d = bus.rd_data;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        tests_run++;
        if (bus.wr_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_pulses: wr_valid=%b frame_err=%b required 0/0", bus.wr_valid, bus.frame_err);
        end
        tests_run++;
        if (bus.wr_addr !== 4'h0 || bus.wr_data !== 16'h0 || bus.rd_data !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_regs: wr_addr=%h wr_data=%h rd_data=%h required 0", bus.wr_addr, bus.wr_data, bus.rd_data);
        end
`ifdef ADC3WIRE_RX_ERRCNT_EN
        tests_run++;
        if (bus.err_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_errcnt: got %0d required 0", bus.err_count);
        end
`endif
        rst = 1'b0;
        repeat (6) @(negedge clk);
        for (int a = 0; a < 16; a++) begin
            do_read(4'(a), d);
            tests_run++;
            if (d !== 16'h0) begin
                tests_failed++;
                $display("FAIL reset_bank[%0d]: got %h required 0000", a, d);
            end
        end
    endtask

    task automatic test_valid_frame();
        logic [15:0] d;
        @(negedge clk);
        bus.rd_addr = 4'h3;
        send_frame(64'h0013ABCD, 32, 8, 12);
        tests_run++;
        if (wr_seen != exp_wr || last_addr !== 4'h3 || last_data !== 16'hABCD) begin
            tests_failed++;
            $display("FAIL valid_frame: writes=%0d addr=%h data=%h required %0d/3/abcd", wr_seen, last_addr, last_data, exp_wr);
        end
        tests_run++;
        if (rd_at_wr !== 16'h0000 || rd_after_wr !== 16'hABCD) begin
            tests_failed++;
            $display("FAIL read_during_write: at=%h after=%h required 0000/abcd", rd_at_wr, rd_after_wr);
        end
        do_read(4'h3, d);
        tests_run++;
        if (d !== 16'hABCD) begin
            tests_failed++;
            $display("FAIL read_back: got %h required abcd", d);
        end
    endtask

    task automatic test_bad_header();
        logic [15:0] d;
        send_frame(64'h0027BEEF, 32, 4, 10);
        tests_run++;
        if (err_seen != exp_err || wr_seen != exp_wr) begin
            tests_failed++;
            $display("FAIL bad_header: errs=%0d writes=%0d required %0d/%0d", err_seen, wr_seen, exp_err, exp_wr);
        end
        do_read(4'h7, d);
        tests_run++;
        if (d !== bank_m[7]) begin
            tests_failed++;
            $display("FAIL bad_header_bank: got %h required %h", d, bank_m[7]);
        end
`ifdef ADC3WIRE_RX_ERRCNT_EN
        tests_run++;
        if (bus.err_count !== 8'(exp_ec)) begin
            tests_failed++;
            $display("FAIL bad_header_errcnt: got %0d required %0d", bus.err_count, exp_ec);
        end
`endif
    endtask

    task automatic test_short_long();
        send_frame(64'h0013_5555, 20, 4, 10);
        send_frame(64'h3_0013_1111, 34, 4, 10);
        tests_run++;
        if (err_seen != exp_err || wr_seen != exp_wr) begin
            tests_failed++;
            $display("FAIL short_long: errs=%0d writes=%0d required %0d/%0d", err_seen, wr_seen, exp_err, exp_wr);
        end
        tests_run++;
        if (bus.wr_addr !== exp_addr || bus.wr_data !== exp_data) begin
            tests_failed++;
            $display("FAIL short_long_wr: addr=%h data=%h required %h/%h", bus.wr_addr, bus.wr_data, exp_addr, exp_data);
        end
    endtask

    task automatic test_idle_clocks();
        logic [15:0] d;
        for (int i = 0; i < 16; i++) begin
            sdata = i[0];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        send_frame(64'h001F1234, 32, 4, 10);
        tests_run++;
        if (wr_seen != exp_wr || err_seen != exp_err || last_addr !== 4'hF || last_data !== 16'h1234) begin
            tests_failed++;
            $display("FAIL idle_clocks: writes=%0d errs=%0d addr=%h data=%h required %0d/%0d/f/1234",
                     wr_seen, err_seen, last_addr, last_data, exp_wr, exp_err);
        end
        do_read(4'hF, d);
        tests_run++;
        if (d !== 16'h1234) begin
            tests_failed++;
            $display("FAIL idle_clocks_bank: got %h required 1234", d);
        end
    endtask

    task automatic test_reset_midframe();
        logic [63:0] f;
        logic [15:0] d;
        int w0, e0;
        f = 64'h00155AA5;
        w0 = wr_seen;
        e0 = err_seen;
        @(negedge clk);
        strobe = 1'b0;
        repeat (4) @(negedge clk);
        send_bits(f, 31, 15, 4);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        send_bits(f, 14, 0, 4);
        repeat (4) @(negedge clk);
        strobe = 1'b1;
        repeat (10) @(negedge clk);
        tests_run++;
        if (wr_seen != w0 || err_seen != e0) begin
            tests_failed++;
            $display("FAIL reset_midframe_pulses: writes=%0d errs=%0d required %0d/%0d", wr_seen, err_seen, w0, e0);
        end
        do_read(4'h5, d);
        tests_run++;
        if (d !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_midframe_bank: got %h required 0000", d);
        end
        send_frame(f, 32, 4, 10);
        do_read(4'h5, d);
        tests_run++;
        if (d !== 16'h5AA5 || wr_seen != exp_wr) begin
            tests_failed++;
            $display("FAIL reset_recover: data=%h writes=%0d required 5aa5/%0d", d, wr_seen, exp_wr);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] f;
        for (int k = 0; k < 4; k++) begin
            f = {$urandom, $urandom};
            f[31:20] = HDR;
            send_frame(f, 32, 4, 2);
        end
        repeat (10) @(negedge clk);
        tests_run++;
        if (wr_seen != exp_wr || last_addr !== exp_addr || last_data !== exp_data) begin
            tests_failed++;
            $display("FAIL back_to_back: writes=%0d addr=%h data=%h required %0d/%h/%h",
                     wr_seen, last_addr, last_data, exp_wr, exp_addr, exp_data);
        end
    endtask

    task automatic test_random();
        logic [63:0] f;
        logic [15:0] d;
        int n, kind;
        for (int k = 0; k < 20; k++) begin
            f = {$urandom, $urandom};
            kind = $urandom_range(0, 9);
            n = 32;
            if (kind < 6) begin
                f[31:20] = HDR;
            end else if (kind < 8) begin
                f[31:20] = HDR ^ 12'($urandom_range(1, 4095));
            end else begin
                n = $urandom_range(1, 40);
                if (n == 32) n = 31;
            end
            send_frame(f, n, $urandom_range(4, 6), $urandom_range(4, 12));
        end
        tests_run++;
        if (wr_seen != exp_wr || err_seen != exp_err) begin
            tests_failed++;
            $display("FAIL random_counts: writes=%0d errs=%0d required %0d/%0d", wr_seen, err_seen, exp_wr, exp_err);
        end
        for (int a = 0; a < 16; a++) begin
            do_read(4'(a), d);
            tests_run++;
            if (d !== bank_m[a]) begin
                tests_failed++;
                $display("FAIL random_bank[%0d]: got %h required %h", a, d, bank_m[a]);
            end
        end
    endtask

    task automatic test_err_saturate();
        int nbad;
`ifdef ADC3WIRE_RX_ERRCNT_EN
        nbad = 300;
`else
        nbad = 20;
`endif
        for (int k = 0; k < nbad; k++) begin
            send_frame(64'h1, 1, 4, 6);
        end
        tests_run++;
        if (err_seen != exp_err) begin
            tests_failed++;
            $display("FAIL err_pulses: got %0d required %0d", err_seen, exp_err);
        end
`ifdef ADC3WIRE_RX_ERRCNT_EN
        tests_run++;
        if (bus.err_count !== 8'(exp_ec)) begin
            tests_failed++;
            $display("FAIL err_saturate: got %0d required %0d", bus.err_count, exp_ec);
        end
`endif
    endtask

    initial begin
        bus.rd_addr = '0;
        model_reset();
        test_reset();
        test_valid_frame();
        test_bad_header();
        test_short_long();
        test_idle_clocks();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        test_err_saturate();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
